// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: request/watchdog inputs and staged reset outputs of the reset sequencer
interface rst_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  sw_rst_req;
  logic                  wdt_en;
  logic                  wdt_kick;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic [1:0]            cause;
  modport master (output sw_rst_req, wdt_en, wdt_kick, input rst_out, ready, cause);
  modport slave (input sw_rst_req, wdt_en, wdt_kick, output rst_out, ready, cause);
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged per-domain reset release with software restart, watchdog and reset cause
module rst_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_CYCLES = 3,
  parameter int WDT_TIMEOUT  = 1000,
  parameter int WDT_WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  rst_sequencer_if.slave bus
);
  localparam int CW = STAGE_CYCLES > 1 ? $clog2(STAGE_CYCLES) : 1;
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [WDT_WIDTH-1:0] wcnt;
  logic                 step_done;
  logic                 trip;
  assign step_done = cnt == CW'(STAGE_CYCLES - 1);
  // a kick on the timeout edge wins, so it suppresses the trip
  assign trip = state == RUN && bus.wdt_en && !bus.wdt_kick && wcnt == WDT_WIDTH'(WDT_TIMEOUT - 1);
  // sequencer FSM; stages release in ascending order, so a left shift clears the next bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ASSERT;
      bus.rst_out <= '1;
      bus.ready   <= 1'b0;
      bus.cause   <= 2'b00;
      cnt         <= '0;
      idx         <= '0;
      wcnt        <= '0;
    end else if (bus.sw_rst_req || trip) begin
      state       <= ASSERT;
      bus.rst_out <= '1;
      bus.ready   <= 1'b0;
      bus.cause   <= bus.sw_rst_req ? 2'b01 : 2'b10;
      cnt         <= '0;
      idx         <= '0;
      wcnt        <= '0;
    end else begin
      case (state)
        ASSERT: begin
          cnt <= step_done ? '0 : cnt + CW'(1);
          if (step_done) state <= RELEASE;
        end
        RELEASE: begin
          cnt <= step_done ? '0 : cnt + CW'(1);
          if (step_done) begin
            bus.rst_out <= bus.rst_out << 1;
            idx         <= idx + IW'(1);
            if (idx == IW'(NUM_STAGES - 1)) begin
              state     <= RUN;
              bus.ready <= 1'b1;
            end
          end
        end
        RUN: wcnt <= (bus.wdt_kick || !bus.wdt_en) ? '0 : wcnt + WDT_WIDTH'(1);
        default: state <= ASSERT;
      endcase
    end
  end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed scoreboard bench for the default and minimal parameter sets
module tb_rst_sequencer;
  localparam int N = 4;
  localparam int S = 3;
  localparam int T = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b1;
  always #5 clk = ~clk;
  rst_sequencer_if #(.NUM_STAGES(N)) bus ();
  rst_sequencer_if #(.NUM_STAGES(1)) cbus ();
  rst_sequencer #(.NUM_STAGES(N), .STAGE_CYCLES(S), .WDT_TIMEOUT(T), .WDT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  rst_sequencer #(.NUM_STAGES(1), .STAGE_CYCLES(1), .WDT_TIMEOUT(2), .WDT_WIDTH(2)) cdut (
    .clk(clk), .rst(rst_c), .bus(cbus.slave)
  );
  typedef struct {
    string      tag;
    logic [6:0] exp;
    bit         c;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  // expected {cause, ready, rst_out} e edges after a sequence start
  function automatic logic [6:0] model(int e, logic [1:0] cs);
    logic [3:0] ro;
    ro = '1;
    for (int k = 0; k < N; k++) if (e >= S * (k + 2)) ro[k] = 1'b0;
    return {cs, e >= S * (N + 1), ro};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_out;
    exp_t x;
    logic [6:0] obs;
    x = sb.pop_front();
    obs = x.c ? {cbus.cause, cbus.ready, 3'b000, cbus.rst_out} : {bus.cause, bus.ready, bus.rst_out};
    total++;
    assert (obs === x.exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
    end
  endtask
  task automatic step(string tag, logic [6:0] e, bit c = 1'b0, bit adv = 1'b1);
    sb.push_back('{tag, e, c});
    if (adv) tick();
    check_out();
  endtask
  task automatic cmp(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int n;
    int errs;
    logic [6:0] ce;
    bus.sw_rst_req = 1'b0;
    bus.wdt_en = 1'b0;
    bus.wdt_kick = 1'b0;
    cbus.sw_rst_req = 1'b0;
    cbus.wdt_en = 1'b1;
    cbus.wdt_kick = 1'b0;
    for (int i = 0; i < 5; i++) step("reset_hold", 7'b00_0_1111);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) step("power_on", model(e, 2'b00));
    bus.sw_rst_req = 1'b1;
    step("sw_run_pulse", model(0, 2'b01));
    bus.sw_rst_req = 1'b0;
    for (int e = 1; e <= 15; e++) step("sw_run_seq", model(e, 2'b01));
    rst = 1'b1;
    bus.sw_rst_req = 1'b1;
    step("rst_with_sw", model(0, 2'b00));
    bus.sw_rst_req = 1'b0;
    step("rst_again", model(0, 2'b00));
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) step("mid_pre", model(e, 2'b00));
    bus.sw_rst_req = 1'b1;
    step("mid_sw", model(0, 2'b01));
    bus.sw_rst_req = 1'b0;
    for (int e = 1; e <= 15; e++) step("mid_restart", model(e, 2'b01));
    bus.sw_rst_req = 1'b1;
    for (int i = 0; i < 3; i++) step("sw_held", model(0, 2'b01));
    bus.sw_rst_req = 1'b0;
    for (int e = 1; e <= 15; e++) step("sw_held_seq", model(e, 2'b01));
    bus.wdt_en = 1'b1;
    n = 0;
    for (int i = 0; i < T + 100; i++) begin
      tick();
      n++;
      if (bus.rst_out == 4'hF) break;
    end
    cmp("wdt_trip_cycle", n, T);
    step("wdt_trip", model(0, 2'b10), 1'b0, 1'b0);
    for (int e = 1; e <= 15; e++) step("wdt_seq", model(e, 2'b10));
    for (int i = 0; i < T - 1; i++) tick();
    bus.wdt_kick = 1'b1;
    step("kick_on_trip", model(15, 2'b10));
    bus.wdt_kick = 1'b0;
    for (int i = 0; i < T - 1; i++) tick();
    bus.sw_rst_req = 1'b1;
    step("sw_on_trip", model(0, 2'b01));
    bus.sw_rst_req = 1'b0;
    bus.wdt_en = 1'b0;
    for (int e = 1; e <= 15; e++) step("sw_trip_seq", model(e, 2'b01));
    bus.wdt_en = 1'b1;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      bus.wdt_kick = (i % 999) == 998;
      tick();
      if (!bus.ready || bus.rst_out != 4'h0) errs++;
    end
    bus.wdt_kick = 1'b0;
    bus.wdt_en = 1'b0;
    cmp("kick_999_no_trip", errs, 0);
    step("kick_999_cause", model(15, 2'b01), 1'b0, 1'b0);
    step("corner_reset", 7'b00_0_000_1, 1'b1, 1'b0);
    rst_c = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      ce = {(e >= 4 ? 2'b10 : 2'b00), !((e % 4) inside {0, 1}), 3'b000, (e % 4) inside {0, 1}};
      step("corner", ce, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset controller that sits directly behind `syscon`: it takes the system clock and the system reset and drives per-domain resets to the rest of the SoC. Stage 0 (core) is released first, then the bus and the peripherals in order. It also re-runs the whole sequence on a software reset request or a watchdog timeout, and it records the cause of the last reset for firmware.

## Interface
- `NUM_STAGES`, 4, number of reset outputs; legal range 1..8.
- `STAGE_CYCLES`, 3, clock cycles per sequencer step; ≥1.
- `WDT_TIMEOUT`, 1000, consecutive unkicked enabled RUN cycles before a watchdog trip; ≥2.
- `WDT_WIDTH`, 16, watchdog counter width; must satisfy 2^WDT_WIDTH ≥ WDT_TIMEOUT.
- `clk`  in  1  system clock from `syscon`.
- `rst`  in  1  system reset from `syscon`: synchronous, active-high. One clock; all state is in the `clk` domain.
- `sw_rst_req`  in  1  software reset request, sampled each cycle.
- `wdt_en`  in  1  watchdog enable.
- `wdt_kick`  in  1  watchdog service, sampled each cycle.
- `rst_out`  out  NUM_STAGES  per-stage reset, active-high; bit 0 is released first.
- `ready`  out  1  high when every stage is released.
- `cause`  out  2  cause of the last reset: 00 = system `rst`, 01 = software, 10 = watchdog; 11 is never driven.

## Operation
States:
- **ASSERT**: all `rst_out` bits are held high for STAGE_CYCLES cycles.
- **RELEASE**: one `rst_out` bit is cleared per STAGE_CYCLES cycles, in ascending bit order.
- **RUN**: all stages are released and the watchdog is active.

Registers: step counter `cnt` (0..STAGE_CYCLES-1), stage index `idx`, watchdog counter `wcnt`.

While `rst` is high, at every edge:
- state = ASSERT; `rst_out` = all ones; `ready` = 0; `cause` = 00.
- `cnt` = 0; `idx` = 0; `wcnt` = 0.
- These are the reset values of all outputs.

ASSERT:
- `cnt` increments each cycle.
- At the edge where `cnt` == STAGE_CYCLES-1: `cnt` becomes 0 and the state moves to RELEASE.

RELEASE:
- `cnt` increments each cycle.
- At the edge where `cnt` == STAGE_CYCLES-1: clear `rst_out[idx]`, set `cnt` to 0, increment `idx`.
- If `idx` == NUM_STAGES-1 at that edge: move to RUN and set `ready` = 1 on the same edge.

RUN watchdog:
- `wcnt` is cleared on `wdt_kick` or when `wdt_en` = 0.
- Otherwise `wcnt` increments.
- At the edge where `wcnt` == WDT_TIMEOUT-1 and it would increment, the watchdog trips.

Restart events (a software request in any state, or a watchdog trip in RUN):
- Next edge: state = ASSERT; `rst_out` = all ones; `ready` = 0.
- `cnt`, `idx` and `wcnt` are cleared.
- `cause` is updated to 01 (software) or 10 (watchdog).

Boundary rules:
- `sw_rst_req` during ASSERT or RELEASE restarts the sequence from ASSERT with `cnt` = 0; stages already released are re-asserted.
- A held `sw_rst_req` keeps the block in ASSERT with `cnt` = 0 each cycle; sequencing resumes once it drops.
- `sw_rst_req` and a watchdog trip on the same edge: software wins, `cause` = 01.
- `rst` high has priority over everything. It restarts mid-sequence at any time and sets `cause` = 00.
- `wdt_kick` on the same edge as the trip condition: the kick wins and there is no trip.
- The watchdog is inactive outside RUN; `wcnt` is held at 0 there.
- `cause` changes only on a restart event or on `rst`. It stays stable through RUN.

## Timing
- Edge numbering: edge 1 is the first rising edge with `rst` = 0.
- Registered outputs: no combinational path from any input to any output.
- `rst_out[k]` falls after edge STAGE_CYCLES·(k+2).
- `ready` rises after edge STAGE_CYCLES·(NUM_STAGES+1), the same edge that clears the last bit.
- Defaults: `rst_out` bits fall after edges 6, 9, 12, 15; `ready` rises after edge 15.
- `sw_rst_req` sampled high at edge n: `rst_out` = all ones and `ready` = 0 after edge n. This is a 1-cycle latency.
- Watchdog trip: occurs at the WDT_TIMEOUT-th consecutive enabled, unkicked RUN cycle. `rst_out` is all ones after that edge.
- Restart duration: a full sequence is STAGE_CYCLES·(NUM_STAGES+1) cycles.

## Test plan
- **Power-on release (defaults):** hold `rst` for 5 cycles, then release. Required: `rst_out` = 1111 through edge 5, 1110 after edge 6, 1100 after 9, 1000 after 12, 0000 after 15; `ready` = 1 after 15; `cause` = 00.
- **Software reset in RUN:** pulse `sw_rst_req` for 1 cycle at edge n. Required: `rst_out` = 1111, `ready` = 0 and `cause` = 01 after edge n; `ready` returns after edge n+15.
- **Watchdog with default timeout:**
  - Set `wdt_en` = 1 with no kicks. Required: the trip occurs on the 1000th RUN cycle, then `cause` = 10 and the sequence restarts.
  - Repeat with a kick every 999 cycles. Required: no trip over 10,000 cycles.
- **Mid-sequence restart:** pulse `sw_rst_req` after edge 10, when `rst_out` = 1100. Required: `rst_out` = 1111 after edge 10; bit 0 falls after edge 16; `ready` rises after edge 25.
- **Simultaneous events:**
  - Assert `sw_rst_req` on the watchdog trip edge. Required: `cause` = 01.
  - Assert `wdt_kick` on the trip edge. Required: no trip.
  - Assert `rst` together with `sw_rst_req`. Required: `cause` = 00.
- **Parameter corner:** NUM_STAGES = 1, STAGE_CYCLES = 1, WDT_TIMEOUT = 2. Required: `rst_out[0]` falls and `ready` rises after edge 2; with `wdt_en` = 1 and no kicks, the watchdog trips after 2 RUN cycles and the sequence repeats every 4 cycles.
